// File: rtl/regfile_dump_reader_pkg.sv
// Shared constants and state encoding for the register-file dump reader.
package regfile_dump_reader_pkg;

    // Defaults shared with the 32x32 register file this block sits beside.
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_REGS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_FIN  = 2'd3
    } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks registers 0..NUM_REGS-1 through a spare read port and streams each
// word out over valid/ready, with last on the final word and a done pulse.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              freeze,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dump_state_e       state_q,     state_d;
    logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [ADDR_W-1:0] out_index_q, out_index_d;
    logic              out_last_q,  out_last_d;
    logic              out_valid_q, out_valid_d;

    // Next-state logic: FSM, read index counter and output holding register.
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d   = ST_LOAD;
                    rd_addr_d = '0;
                end
            end
            ST_LOAD: begin
                // rd_data is combinational for rd_addr, so capture it now.
                out_data_d  = rd_data;
                out_index_d = rd_addr_q;
                out_last_d  = (rd_addr_q == LAST_IDX);
                out_valid_d = 1'b1;
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        out_last_d = 1'b0;
                        state_d    = ST_FIN;
                    end else begin
                        // Stops at LAST_IDX, so the increment never wraps.
                        rd_addr_d = rd_addr_q + 1'b1;
                        state_d   = ST_LOAD;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides any same-cycle handshake: the word is not transferred.
        if (abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rd_addr_q   <= '0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign rd_addr   = rd_addr_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    // Freeze covers the snapshot window only; it drops as FIN is entered.
    assign freeze    = (state_q == ST_LOAD) || (state_q == ST_SEND);
    assign busy      = (state_q != ST_IDLE);
    // An abort landing in FIN cancels the pulse as well.
    assign done      = (state_q == ST_FIN) && !abort;

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
Hardware counterpart of the register-file dump: on a start request it walks every register through a dedicated read port and streams each word out over a valid/ready interface, ending with a last/done indication. It sits beside the 32x32 register file on its spare read port and feeds a debug sink (UART bridge, trace FIFO, testbench monitor). It asserts a freeze request so the datapath can suppress RegWrite, which keeps the snapshot coherent.

Parameters:
DATA_W, 32, register word width
ADDR_W, 5, register index width
NUM_REGS, 32, registers dumped, indices 0..NUM_REGS-1; must satisfy NUM_REGS <= 2**ADDR_W

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin dump; sampled only in IDLE
abort  input  1  synchronous cancel; valid in any state
rd_addr  output  ADDR_W  register index to the register-file read port
rd_data  input  DATA_W  combinational read data for rd_addr, valid in the same cycle
freeze  output  1  high while a dump is active; datapath holds off register writes
out_valid  output  1  out_data/out_index/out_last are valid
out_ready  input  1  sink accepts the word this cycle
out_data  output  DATA_W  register contents
out_index  output  ADDR_W  index of out_data
out_last  output  1  high with the final word (index NUM_REGS-1)
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. While rst_n=0: state=IDLE; rd_addr, out_data, out_index=0; out_valid, out_last, freeze, busy, done=0.
- Reset mid-dump: the block returns to IDLE immediately. No done pulse is produced. Nothing resumes after reset.
- States: IDLE, LOAD, SEND, FIN.
- IDLE:
  - start=1 (and abort=0) -> LOAD, with rd_addr=0, busy=1, freeze=1.
  - start is ignored in every other state.
- LOAD (one cycle): out_data<=rd_data, out_index<=rd_addr, out_last<=(rd_addr==NUM_REGS-1), out_valid<=1 -> SEND.
- SEND:
  - out_valid=1. out_data, out_index and out_last are held stable while out_ready=0.
  - On out_valid&&out_ready with out_last=0: out_valid<=0, rd_addr<=rd_addr+1 -> LOAD.
  - On out_valid&&out_ready with out_last=1: out_valid<=0 -> FIN.
- FIN (one cycle): done=1, busy=1 -> IDLE. freeze deasserts on entry to FIN.
- abort:
  - abort=1 in LOAD/SEND/FIN -> IDLE next cycle. out_valid, out_last, freeze, busy drop to 0; no done pulse.
  - abort has priority over the out_ready handshake in the same cycle; the word is treated as not transferred.
  - abort=1 together with start in IDLE -> stays IDLE.
- Throughput: at most one word per 2 cycles. With out_ready tied high, a full dump takes 2*NUM_REGS+2 cycles from start to the done pulse.
- Widths: rd_addr increments in ADDR_W bits and never wraps, because it stops at NUM_REGS-1. Data passes through unmodified.
- Register 0 is dumped like any other register; its value comes from rd_data, not a hard-wired constant.
- Writes that occur despite freeze are not detected. Coherence is the datapath's responsibility.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE=2'd0, LOAD=2'd1, SEND=2'd2, FIN=2'd3);
  - the default DATA_W, ADDR_W and NUM_REGS constants shared with the register file.
- No sub-module is needed. The FSM, index counter and output register form one module.
- The output holding register may be factored as out_stage_reg if it is reused by other debug streamers.

Test Plan:
- Reset and idle: rst_n=0 asserted mid-SEND at word 7 -> all outputs 0 while reset is low; after release, IDLE, no done pulse, no out_valid.
- Full dump, ready tied high: register file preloaded with i*32'h01010101, start pulsed -> 32 words in index order 0..31, out_data[5]=32'h05050505, out_last only at index 31, done pulse exactly 66 cycles after start.
- Backpressure: out_ready low for 4 cycles during word 3 -> out_data/out_index stay at 3 with out_valid=1 throughout, then word 4 follows; no word is lost or duplicated.
- Abort: abort=1 in the same cycle that word 10 handshakes -> IDLE next cycle, freeze=0, done never asserted, word 10 not counted. A new start afterwards restarts at index 0.
- Start ignored when busy: start pulses during SEND of word 2 -> the sequence continues unaffected with exactly 32 words. start held high through FIN -> a second dump begins from IDLE on the following cycle.
- NUM_REGS=4 instance: 4 words, out_last on index 3, done 10 cycles after start with ready high.
